// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : iterative_alu
// Brief    : Multi-cycle EX-stage ALU: single-cycle logic/arith, shift-add
//            MUL/MULHU and restoring DIVU/REMU behind a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       sl,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             sign,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [3:0] C_OP_ADD   = 4'b0000;
    localparam logic [3:0] C_OP_SUB   = 4'b0001;
    localparam logic [3:0] C_OP_AND   = 4'b0010;
    localparam logic [3:0] C_OP_OR    = 4'b0011;
    localparam logic [3:0] C_OP_XOR   = 4'b0100;
    localparam logic [3:0] C_OP_SLT   = 4'b0101;
    localparam logic [3:0] C_OP_SLTU  = 4'b0110;
    localparam logic [3:0] C_OP_MUL   = 4'b1000;
    localparam logic [3:0] C_OP_MULHU = 4'b1001;
    localparam logic [3:0] C_OP_DIVU  = 4'b1010;
    localparam logic [3:0] C_OP_REMU  = 4'b1011;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_hi;

    logic               w_is_mul;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_quick;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_q_next;

    assign w_is_mul = (sl == C_OP_MUL)  || (sl == C_OP_MULHU);
    assign w_is_div = (sl == C_OP_DIVU) || (sl == C_OP_REMU);

    // DIVU/REMU only reach this path when the divisor is zero (RISC-V results).
    always_comb begin
        w_quick = '0;
        case (sl)
            C_OP_ADD:  w_quick = in1 + in2;
            C_OP_SUB:  w_quick = in1 - in2;
            C_OP_AND:  w_quick = in1 & in2;
            C_OP_OR:   w_quick = in1 | in2;
            C_OP_XOR:  w_quick = in1 ^ in2;
            C_OP_SLT:  w_quick = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            C_OP_SLTU: w_quick = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            C_OP_DIVU: w_quick = '1;
            C_OP_REMU: w_quick = in1;
            default:   w_quick = '0;
        endcase
    end

    // Multiplier lives in the low half of the accumulator and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // A borrow out of the trial subtraction means the shifted remainder is below the divisor.
    assign w_div_shift = {r_rem, r_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_rem_next  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_q_next    = {r_q[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_opnd  <= '0;
            r_hi    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_hi  <= sl[0];
                        if (w_is_mul) begin
                            r_opnd  <= in1;
                            r_acc   <= {{WIDTH{1'b0}}, in2};
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else if (w_is_div && (in2 != '0)) begin
                            r_opnd  <= in2;
                            r_q     <= in1;
                            r_rem   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end else begin
                            r_out   <= w_quick;
                            r_dbz   <= w_is_div;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_out   <= r_hi ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_out   <= r_hi ? w_rem_next : w_q_next;
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out         = r_out;
    assign zero        = (r_out == '0);
    assign sign        = r_out[WIDTH-1];
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_alu
// Brief    : Self-checking bench for iterative_alu against a plain-arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_iterative_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in1, in2;
    logic [3:0]   sl;
    logic [W-1:0] out;
    logic         zero, sign, busy, done, div_by_zero;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    iterative_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .sl(sl),
        .out(out), .zero(zero), .sign(sign), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_out(input logic [3:0] op, input logic [W-1:0] a, b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0110: return (a < b) ? 32'd1 : 32'd0;
            4'b1000: return p[31:0];
            4'b1001: return p[63:32];
            4'b1010: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'b1011: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
        if (op == 4'b1000 || op == 4'b1001) return W + 1;
        if ((op == 4'b1010 || op == 4'b1011) && b != 0) return W + 1;
        return 1;
    endfunction

    // Launches one op from IDLE (called at a negedge), returns at the following IDLE negedge.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, b,
                         output int lat, output int bcnt, output logic [W-1:0] res,
                         output logic dbz, output logic zf, output logic sf,
                         output logic bdone, output bit stable);
        logic [W-1:0] o0;
        o0 = out; stable = 1'b1;
        sl = op; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; in1 = $urandom; in2 = $urandom; sl = 4'($urandom);
        lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (out !== o0) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        res = out; dbz = div_by_zero; zf = zero; sf = sign; bdone = busy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; sl = '0;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({out, zero, sign, busy, done, div_by_zero} !== {32'd0, 5'b10000})
            $display("FAIL reset_state: got out=%h z=%b s=%b b=%b d=%b dbz=%b required out=0 z=1 others 0",
                     out, zero, sign, busy, done, div_by_zero);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [3:0]   ops[12] = '{4'b0000, 4'b0001, 4'b0101, 4'b0110, 4'b1000, 4'b1001,
                                  4'b1010, 4'b1011, 4'b1010, 4'b1011, 4'b0111, 4'b0000};
        logic [W-1:0] as[12]  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd100, 32'd100, 32'd9, 32'd9, 32'h1234, 32'd1};
        logic [W-1:0] bs[12]  = '{32'd1, 32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'h5678, 32'd2};
        logic [W-1:0] exp_o[12] = '{32'h8000_0000, 32'd0, 32'd1, 32'd0, 32'd1, 32'hFFFF_FFFE,
                                    32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9, 32'd0, 32'd3};
        int           exp_l[12] = '{1, 1, 1, 1, 33, 33, 33, 33, 1, 1, 1, 1};
        int           exp_b[12] = '{0, 0, 0, 0, 32, 32, 32, 32, 0, 0, 0, 0};
        logic         exp_d[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        int lat, bcnt; logic [W-1:0] res; logic dbz, zf, sf, bd; bit st;
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], lat, bcnt, res, dbz, zf, sf, bd, st);
            chk_cnt++; if (res !== exp_o[i] || zf !== (exp_o[i] == 0) || sf !== exp_o[i][31])
                $display("FAIL directed_out[%0d]: got %h z=%b s=%b required %h", i, res, zf, sf, exp_o[i]);
            else pass_cnt++;
            chk_cnt++; if (lat != exp_l[i] || bcnt != exp_b[i] || bd !== 1'b0)
                $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d busy_at_done=%b required lat=%0d busy=%0d",
                         i, lat, bcnt, bd, exp_l[i], exp_b[i]);
            else pass_cnt++;
            chk_cnt++; if (dbz !== exp_d[i] || !st)
                $display("FAIL directed_dbz_hold[%0d]: got dbz=%b stable=%0d required dbz=%b stable=1",
                         i, dbz, st, exp_d[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [3:0] oplist[12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                   4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1111};
        int lat, bcnt; logic [W-1:0] res, a, b, e; logic dbz, zf, sf, bd; bit st;
        logic [3:0] op;
        for (int i = 0; i < 60; i++) begin
            op = oplist[$urandom_range(0, 11)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            e = ref_out(op, a, b);
            do_op(op, a, b, lat, bcnt, res, dbz, zf, sf, bd, st);
            chk_cnt++; if (res !== e || zf !== (e == 0) || sf !== e[31] ||
                           dbz !== ((op == 4'b1010 || op == 4'b1011) && b == 0))
                $display("FAIL random_out op=%b a=%h b=%h: got %h dbz=%b required %h", op, a, b, res, dbz, e);
            else pass_cnt++;
            chk_cnt++; if (lat != ref_lat(op, b) || bcnt != ref_lat(op, b) - 1 || !st)
                $display("FAIL random_timing op=%b: got lat=%0d busy=%0d stable=%0d required lat=%0d",
                         op, lat, bcnt, st, ref_lat(op, b));
            else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy();
        int lat; int extra;
        sl = 4'b1000; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 5) begin sl = 4'b0000; in1 = 32'd1; in2 = 32'd2; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk); lat++;
        end
        start = 1'b0;
        chk_cnt++; if (lat != 33 || out !== 32'd1)
            $display("FAIL start_while_busy: got lat=%0d out=%h required lat=33 out=00000001", lat, out);
        else pass_cnt++;
        extra = 0;
        repeat (4) begin @(negedge clk); if (done) extra++; end
        chk_cnt++; if (extra != 0)
            $display("FAIL no_spurious_done: got %0d extra done pulses required 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_div();
        int lat, bcnt, seen; logic [W-1:0] res; logic dbz, zf, sf, bd; bit st;
        do_op(4'b1010, 32'd9, 32'd0, lat, bcnt, res, dbz, zf, sf, bd, st);
        sl = 4'b1010; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_cnt++; if ({out, zero, busy, done, div_by_zero} !== {32'd0, 4'b1000})
            $display("FAIL reset_mid_div: got out=%h z=%b b=%b d=%b dbz=%b required out=0 z=1 b=0 d=0 dbz=0",
                     out, zero, busy, done, div_by_zero);
        else pass_cnt++;
        seen = 0;
        repeat (40) begin @(negedge clk); if (done || busy) seen++; end
        chk_cnt++; if (seen != 0)
            $display("FAIL reset_abort: got %0d cycles with done/busy after reset required 0", seen);
        else pass_cnt++;
        do_op(4'b0000, 32'd3, 32'd4, lat, bcnt, res, dbz, zf, sf, bd, st);
        chk_cnt++; if (res !== 32'd7 || lat != 1)
            $display("FAIL add_after_reset: got out=%h lat=%0d required 00000007 lat=1", res, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ndone; bit ok;
        ndone = 0; ok = 1'b1;
        sl = 4'b0000; in2 = 32'd100; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            in1 = 32'(k);
            @(posedge clk); @(negedge clk);
            if (done) begin
                ndone++;
                if ((k % 2) == 0 || out !== 32'(k + 100)) ok = 1'b0;
            end
        end
        start = 1'b0;
        chk_cnt++; if (ndone != 5 || !ok)
            $display("FAIL back_to_back: got %0d done pulses ok=%0d required 5 ok=1", ndone, ok);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid_div();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
